zapper_hit_detector: RTL and testbench
======================================

Name: zapper_hit_detector

Overview:
- Light-gun receive side of the target-flash protocol.
- The target drawer paints a white target for a fixed number of frames after a shot. This block is the other end: it debounces the gun trigger and issues `shot_fired`, then samples the gun photodiode during the flash window. It reports `duck_hit` or a miss to game logic and to the target drawer.
- Reports gun presence as `gun_is_connected`.
- Sits in the VGA clock domain next to the drawing chain.

Parameters:
- TARGET_FRAMES, 60, frame-window length; must equal the target drawer's value.
- SETTLE_FRAMES, 2, frames after the shot that are ignored for hit sampling (display/sensor settling).
- HIT_THRESHOLD, 16, active-light clocks within one frame that constitute a hit.
- DEBOUNCE_CYCLES, 65000, clocks the synchronised trigger must stay stable before its level is accepted.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- trigger_raw  in  1  asynchronous gun trigger, 1 = pressed
- light_n_raw  in  1  asynchronous photodiode output, 0 = light sensed
- gun_detect_raw  in  1  asynchronous presence pin, 1 = gun plugged in
- new_frame  in  1  one-cycle pulse at frame start, same source as the target drawer
- vblnk  in  1  vertical blank from the VGA timing stream
- shot_fired  out  1  one-cycle pulse per accepted trigger press
- duck_hit  out  1  level: hit detected for the current shot
- shot_missed  out  1  one-cycle pulse: window ended without a hit
- gun_is_connected  out  1  synchronised gun_detect_raw

Behaviour:
- Reset: clk and rst_n only; reset is asynchronous, active-low. All outputs are 0; FSM = IDLE; all counters = 0; synchroniser flops = 0, except the light synchroniser, which resets to 1 (dark).
- Input synchronisers: each raw input passes through a 2-FF synchroniser. `gun_is_connected` is the second-stage value, i.e. 2 cycles of latency.
- Trigger debounce:
  - The counter is cleared whenever the synchronised trigger equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES-1 the debounced level takes the new value and the counter clears.
  - A rising edge of the debounced level while FSM = IDLE and `gun_is_connected` = 1 produces `shot_fired` on the next cycle.
  - Presses in any other state are ignored; they produce no pulse and are not queued.
- Frame counter:
  - Cleared to 0 on `shot_fired`; increments on each `new_frame` while FSM ≠ IDLE.
  - Width = $clog2(TARGET_FRAMES+1).
- Light counter:
  - Counts cycles where synchronised light = 0 and vblnk = 0.
  - Saturates at HIT_THRESHOLD; cleared on every `new_frame` and on `shot_fired`.
- FSM states: IDLE, SETTLE, SAMPLE.
  - IDLE → SETTLE on `shot_fired`. The same cycle clears `duck_hit`.
  - SETTLE → SAMPLE on the `new_frame` that makes frame_cnt = SETTLE_FRAMES. Light-counter results in SETTLE are discarded.
  - SAMPLE → IDLE with `duck_hit` <= 1 when the light counter reaches HIT_THRESHOLD. `duck_hit` stays high until the next `shot_fired`.
  - SAMPLE → IDLE with a `shot_missed` pulse on the `new_frame` that makes frame_cnt = TARGET_FRAMES-1 with no hit.
  - If a hit and that final `new_frame` occur in the same cycle, hit wins and there is no miss pulse.
- Abort: if `gun_is_connected` drops in SETTLE or SAMPLE, the FSM returns to IDLE next cycle. No hit, no miss; counters are cleared.
- Mid-operation reset: `rst_n` low at any time returns everything to reset values immediately; no pulses are emitted.
- SETTLE_FRAMES ≥ TARGET_FRAMES-1 is illegal; this is checked by an elaboration assertion.

Optional Feature:
- Macro: ZAPPER_ANTI_CHEAT_EN.
- Defined: if the light counter reaches HIT_THRESHOLD during SETTLE (gun aimed at a lamp or bright background), the FSM goes to IDLE and pulses `shot_missed`; `duck_hit` stays 0.
- Undefined: SETTLE light counts are ignored, as above.

Decomposition:
- Package zapper_pkg holds:
  - state enum zapper_state_t {IDLE, SETTLE, SAMPLE};
  - the shared TARGET_FRAMES default constant, also used by the target drawer.
- Sub-module sync_debounce: 2-FF synchroniser plus DEBOUNCE_CYCLES stability counter, parameterised. Instantiated for the trigger.
- Light and gun_detect use bare 2-FF synchronisers, inline.

Test Plan:
All scenarios use sim parameters DEBOUNCE_CYCLES=4, SETTLE_FRAMES=2, TARGET_FRAMES=6, HIT_THRESHOLD=3, with new_frame every 100 clocks and vblnk=0.
1. Bounce rejection: gun connected; trigger_raw toggles every 2 clocks for 20 clocks, then holds high → no pulse during bouncing; exactly one `shot_fired` pulse, 2 sync + 4 debounce + 1 cycles after the final rise.
2. Hit: after the shot, light_n_raw held 0 for 5 clocks starting 10 clocks after the 2nd `new_frame` → `duck_hit` rises 2+3 cycles after light onset and stays high; no `shot_missed`.
3. Miss: after the shot, light stays dark → one `shot_missed` pulse on the 5th `new_frame`; `duck_hit` = 0; FSM returns to IDLE; a second trigger press is then accepted.
4. Ignored press and hit clear: trigger pressed while in SAMPLE → no `shot_fired`. Later, a `duck_hit`=1 followed by a new press → `duck_hit` clears in the cycle `shot_fired` fires.
5. Abort: gun_detect_raw → 0 during SAMPLE → IDLE within 3 cycles, no `duck_hit`/`shot_missed`. Separately, rst_n pulsed low mid-SETTLE → all outputs 0 immediately.
6. Anti-cheat: with ZAPPER_ANTI_CHEAT_EN defined, light active 4 clocks during SETTLE → `shot_missed` pulse within 6 cycles, `duck_hit` = 0. Without the macro, the same stimulus gives no pulse until the window end.

Source files
------------

// File: rtl/zapper_pkg.sv
// Shared types and constants for the light-gun receive path.
// TARGET_FRAMES_DEF is also used by the target drawer.
package zapper_pkg;

  localparam int unsigned TARGET_FRAMES_DEF = 60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2
  } zapper_state_t;

endpackage

// File: rtl/zapper_hit_detector_sync_debounce.sv
// Two-flop synchroniser plus stability counter.
// rise_o pulses one cycle after the debounced level goes high.
module sync_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= d_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign rise_o = level_q & ~prev_q;

endmodule

// File: rtl/zapper_hit_detector.sv
// Light-gun trigger debounce and flash-window hit sampling.
// Define ZAPPER_ANTI_CHEAT_EN to reject shots lit during settling.
module zapper_hit_detector
  import zapper_pkg::*;
#(
  parameter int unsigned TARGET_FRAMES   = TARGET_FRAMES_DEF,
  parameter int unsigned SETTLE_FRAMES   = 2,
  parameter int unsigned HIT_THRESHOLD   = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 65000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trigger_raw,
  input  logic light_n_raw,
  input  logic gun_detect_raw,
  input  logic new_frame,
  input  logic vblnk,
  output logic shot_fired,
  output logic duck_hit,
  output logic shot_missed,
  output logic gun_is_connected
);

  localparam int unsigned FW = $clog2(TARGET_FRAMES + 1);
  localparam int unsigned LW = $clog2(HIT_THRESHOLD + 1);
  localparam logic [FW-1:0] SETTLE_LAST = FW'(SETTLE_FRAMES);
  localparam logic [FW-1:0] WINDOW_LAST = FW'(TARGET_FRAMES - 1);
  localparam logic [LW-1:0] LIGHT_MAX   = LW'(HIT_THRESHOLD);
  localparam logic [LW-1:0] LIGHT_NEAR  = LW'(HIT_THRESHOLD - 1);

  if (SETTLE_FRAMES >= TARGET_FRAMES - 1) begin : g_cfg_err
    $error("SETTLE_FRAMES must be below TARGET_FRAMES-1");
  end

  zapper_state_t state_q, state_d;

  logic          g1_q, g2_q;
  logic          l1_q, l2_q;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d, frame_inc;
  logic [LW-1:0] light_cnt_q, light_cnt_d;
  logic          shot_fired_q, shot_fired_d;
  logic          shot_missed_q, shot_missed_d;
  logic          duck_hit_q, duck_hit_d;
  logic          trig_rise;
  logic          fire, abort, lit, reach;
  logic          settle_end, win_end;

  sync_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (trigger_raw),
    .rise_o(trig_rise)
  );

  // Light sync idles at 1 so reset reads as "dark".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g1_q <= 1'b0;
      g2_q <= 1'b0;
      l1_q <= 1'b1;
      l2_q <= 1'b1;
    end else begin
      g1_q <= gun_detect_raw;
      g2_q <= g1_q;
      l1_q <= light_n_raw;
      l2_q <= l1_q;
    end
  end

  assign fire       = trig_rise && (state_q == IDLE) && g2_q;
  assign abort      = (state_q != IDLE) && !g2_q;
  assign lit        = !l2_q && !vblnk;
  assign reach      = lit && (light_cnt_q >= LIGHT_NEAR);
  assign frame_inc  = frame_cnt_q + FW'(1);
  assign settle_end = new_frame && (frame_inc == SETTLE_LAST);
  assign win_end    = new_frame && (frame_inc == WINDOW_LAST);

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (fire || abort) begin
      frame_cnt_d = '0;
    end else if (new_frame && state_q != IDLE) begin
      frame_cnt_d = frame_inc;
    end
  end

  always_comb begin
    light_cnt_d = light_cnt_q;
    if (fire || abort || new_frame) begin
      light_cnt_d = '0;
    end else if (lit && light_cnt_q != LIGHT_MAX) begin
      light_cnt_d = light_cnt_q + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (fire) state_d = SETTLE;
      end
      SETTLE: begin
        if (abort) state_d = IDLE;
`ifdef ZAPPER_ANTI_CHEAT_EN
        else if (reach) state_d = IDLE;
`endif
        else if (settle_end) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (abort || reach || win_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A hit on the final frame edge wins over the miss.
  always_comb begin
    shot_fired_d  = fire;
    shot_missed_d = 1'b0;
    duck_hit_d    = duck_hit_q;
    if (fire) duck_hit_d = 1'b0;
    if (state_q == SAMPLE && !abort) begin
      if (reach) begin
        duck_hit_d = 1'b1;
      end else if (win_end) begin
        shot_missed_d = 1'b1;
      end
    end
`ifdef ZAPPER_ANTI_CHEAT_EN
    if (state_q == SETTLE && !abort && reach) begin
      shot_missed_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q   <= '0;
      light_cnt_q   <= '0;
      shot_fired_q  <= 1'b0;
      shot_missed_q <= 1'b0;
      duck_hit_q    <= 1'b0;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      light_cnt_q   <= light_cnt_d;
      shot_fired_q  <= shot_fired_d;
      shot_missed_q <= shot_missed_d;
      duck_hit_q    <= duck_hit_d;
    end
  end

  assign shot_fired       = shot_fired_q;
  assign shot_missed      = shot_missed_q;
  assign duck_hit         = duck_hit_q;
  assign gun_is_connected = g2_q;

endmodule

// File: tb/tb_zapper_hit_detector.sv
// Directed plus randomized bench for zapper_hit_detector.
// Reference model tracks shot windows by frame count, not FSM state.
module tb_zapper_hit_detector;

  localparam int DEB = 4;
  localparam int SET = 2;
  localparam int TGT = 6;
  localparam int THR = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic trigger_raw = 1'b0;
  logic light_n_raw = 1'b1;
  logic gun_detect_raw = 1'b0;
  logic new_frame = 1'b0;
  logic vblnk = 1'b0;
  logic shot_fired, duck_hit, shot_missed, gun_is_connected;

  always #5 clk = ~clk;

  zapper_hit_detector #(
    .TARGET_FRAMES  (TGT),
    .SETTLE_FRAMES  (SET),
    .HIT_THRESHOLD  (THR),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .trigger_raw     (trigger_raw),
    .light_n_raw     (light_n_raw),
    .gun_detect_raw  (gun_detect_raw),
    .new_frame       (new_frame),
    .vblnk           (vblnk),
    .shot_fired      (shot_fired),
    .duck_hit        (duck_hit),
    .shot_missed     (shot_missed),
    .gun_is_connected(gun_is_connected)
  );

  int n_vec = 0;
  int n_fail = 0;
  int nf_phase = 0;
  int nf_seen = 0;
  int shots = 0;
  int misses = 0;

  bit trig_h[$];
  bit light_h[$];
  bit gun_h[$];

  bit m_level, m_rise, m_open, m_hit;
  bit m_fired, m_missed, m_gun;
  int m_frames, m_light;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t",
             tag, obs, exp, $time);
    end
  endtask

  // Raw input sampled d edges ago; before reset release it is the reset value.
  function automatic bit past_trig(input int d);
    int idx = trig_h.size() - 1 - d;
    return (idx >= 0) ? trig_h[idx] : 1'b0;
  endfunction

  function automatic bit past_light(input int d);
    int idx = light_h.size() - 1 - d;
    return (idx >= 0) ? light_h[idx] : 1'b1;
  endfunction

  function automatic bit past_gun(input int d);
    int idx = gun_h.size() - 1 - d;
    return (idx >= 0) ? gun_h[idx] : 1'b0;
  endfunction

  task automatic model_reset();
    trig_h.delete();
    light_h.delete();
    gun_h.delete();
    m_level = 0; m_rise = 0; m_open = 0; m_hit = 0;
    m_fired = 0; m_missed = 0; m_gun = 0;
    m_frames = 0; m_light = 0;
  endtask

  task automatic model_step();
    bit gconn, lit, reach, fire, abort, stable, nl;
    int fn;
    trig_h.push_back(trigger_raw);
    light_h.push_back(light_n_raw);
    gun_h.push_back(gun_detect_raw);
    if (trig_h.size() > 16) begin
      void'(trig_h.pop_front());
      void'(light_h.pop_front());
      void'(gun_h.pop_front());
    end
    gconn = past_gun(2);
    lit   = !past_light(2) && !vblnk;
    reach = lit && (m_light + 1 >= THR);
    fire  = m_rise && !m_open && gconn;
    abort = m_open && !gconn;
    fn    = m_frames + (new_frame ? 1 : 0);
    m_fired  = fire;
    m_missed = 0;
    if (fire) begin
      m_hit = 0; m_open = 1; m_frames = 0;
    end else if (abort) begin
      m_open = 0; m_frames = 0;
    end else if (m_open) begin
      if (m_frames >= SET) begin
        if (reach) begin
          m_hit = 1; m_open = 0;
        end else if (new_frame && fn == TGT - 1) begin
          m_missed = 1; m_open = 0;
        end
      end
`ifdef ZAPPER_ANTI_CHEAT_EN
      else if (reach) begin
        m_missed = 1; m_open = 0;
      end
`endif
      m_frames = fn;
    end
    if (fire || abort || new_frame) m_light = 0;
    else if (lit && m_light < THR) m_light++;
    // level flips once the synced trigger differed for DEB samples in a row
    stable = 1;
    for (int j = 0; j < DEB; j++)
      if (past_trig(2 + j) == m_level) stable = 0;
    nl = stable ? !m_level : m_level;
    m_rise  = nl && !m_level;
    m_level = nl;
    m_gun   = past_gun(1);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    if (new_frame) nf_seen++;
    #1;
    check("cycle",
          {28'd0, shot_fired, duck_hit, shot_missed, gun_is_connected},
          {28'd0, m_fired, m_hit, m_missed, m_gun});
    if (shot_fired) shots++;
    if (shot_missed) misses++;
    @(negedge clk);
    nf_phase = (nf_phase + 1) % 100;
    new_frame = (nf_phase == 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return shot_fired;
      1: return duck_hit;
      default: return shot_missed;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (sig(sel) === 1'b1) break;
    end
  endtask

  task automatic wait_frames(input int n);
    int start = nf_seen;
    int b = 0;
    while (nf_seen < start + n && b < 100 * n + 100) begin
      tick();
      b++;
    end
    check("frame_wait", (nf_seen - start >= n) ? 1 : 0, 1);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    new_frame = 1'b0;
    #1;
    check("reset_outputs",
          {28'd0, shot_fired, duck_hit, shot_missed, gun_is_connected},
          32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, s0, m0, f0, hold, gun_off;
    model_reset();
    #2;
    reset_dut();
    gun_detect_raw = 1'b1;
    ticks(10);

    // bounce rejection, then one clean press
    s0 = shots;
    for (int i = 0; i < 10; i++) begin
      trigger_raw = ~trigger_raw;
      ticks(2);
    end
    check("bounce_quiet", shots - s0, 0);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("shot_latency", n, 7);

    // hit in the sampling window
    m0 = misses;
    wait_frames(2);
    ticks(10);
    light_n_raw = 1'b0;
    wait_sig(1, 10, n);
    light_n_raw = 1'b1;
    check("hit_latency", n, 5);
    ticks(200);
    check("hit_held", duck_hit, 1);
    check("hit_no_miss", misses - m0, 0);

    // miss at window end, then re-arm
    trigger_raw = 1'b0;
    ticks(20);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("shot2_latency", n, 7);
    f0 = nf_seen;
    m0 = misses;
    wait_sig(2, 700, n);
    check("miss_frame", nf_seen - f0, 5);
    check("miss_no_hit", duck_hit, 0);
    ticks(5);
    check("miss_once", misses - m0, 1);
    trigger_raw = 1'b0;
    ticks(20);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("rearm_shot", n, 7);

    // press during sampling is dropped; new shot clears hit
    wait_frames(2);
    ticks(5);
    trigger_raw = 1'b0;
    ticks(10);
    s0 = shots;
    trigger_raw = 1'b1;
    ticks(40);
    check("ignored_press", shots - s0, 0);
    light_n_raw = 1'b0;
    wait_sig(1, 10, n);
    light_n_raw = 1'b1;
    check("hit2_latency", n, 5);
    trigger_raw = 1'b0;
    ticks(10);
    check("hit_before_press", duck_hit, 1);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("clear_shot", n, 7);
    check("hit_cleared", duck_hit, 0);

    // gun unplugged mid-sample aborts silently
    wait_frames(2);
    ticks(5);
    m0 = misses;
    gun_detect_raw = 1'b0;
    ticks(2);
    check("gun_drop", gun_is_connected, 0);
    ticks(600);
    check("abort_no_miss", misses - m0, 0);
    check("abort_no_hit", duck_hit, 0);
    gun_detect_raw = 1'b1;
    ticks(5);
    trigger_raw = 1'b0;
    ticks(10);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("post_abort_shot", n, 7);
    trigger_raw = 1'b0;
    reset_dut();

    // light during settling
    ticks(10);
    trigger_raw = 1'b1;
    wait_sig(0, 20, n);
    check("ac_shot", n, 7);
    f0 = nf_seen;
    wait_frames(1);
    ticks(10);
    light_n_raw = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 4) light_n_raw = 1'b1;
      tick();
      if (shot_missed && n == 0) n = i + 1;
    end
`ifdef ZAPPER_ANTI_CHEAT_EN
    check("ac_miss_latency", n, 5);
    check("ac_no_hit", duck_hit, 0);
`else
    check("ac_no_early_miss", n, 0);
    wait_sig(2, 700, n);
    check("ac_window_end", nf_seen - f0, 5);
`endif

    // randomized traffic against the model
    trigger_raw = 1'b0;
    ticks(20);
    hold = 0;
    gun_off = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        trigger_raw = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 12);
      end
      hold--;
      light_n_raw = ($urandom_range(0, 3) != 0);
      vblnk = ($urandom_range(0, 15) == 0);
      if (gun_off > 0) begin
        gun_off--;
        gun_detect_raw = (gun_off == 0);
      end else if ($urandom_range(0, 599) == 0) begin
        gun_off = $urandom_range(1, 30);
        gun_detect_raw = 1'b0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
